// File: rtl/conv_pkg.sv
// Shared defaults, pipeline latency and the signed saturation helper used by
// conv_vec_mult_pipe and its lane multipliers.
package conv_pkg;

  localparam int LANES_DEF = 25;
  localparam int DW_DEF    = 16;
  localparam int FRAC_DEF  = 8;
  localparam int PIPE_LAT  = 3;
  localparam int WIDE_W    = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Clamp a sign-extended value into the signed range of a w-bit result.
  function automatic wide_t sat_s(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/conv_mult_lane.sv
// One signed DW x DW multiplier lane with clock enable and a lane enable
// that forces the registered product to zero.
module conv_mult_lane import conv_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   ce_i,
  input  logic                   en_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [2*DW-1:0] prod_o
);

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod_d;
  logic signed [2*DW-1:0] prod_q;

  // Full-width operands keep -(2^(DW-1))^2 from wrapping the sign.
  always_comb begin
    a_ext  = (2*DW)'(a_i);
    b_ext  = (2*DW)'(b_i);
    prod_d = en_i ? a_ext * b_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (ce_i) begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/conv_vec_mult_pipe.sv
// Three-stage vector multiplier with per-lane scaled products and a scaled dot
// product. Define CONV_VEC_MULT_SAT_EN to saturate results instead of wrapping.
module conv_vec_mult_pipe import conv_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_v,
  input  logic                          halt,
  input  logic [LANES-1:0]              lane_mask,
  input  logic [LANES*DW-1:0]           in_fea_w,
  input  logic [LANES*DW-1:0]           a_mx_w,
  output logic [LANES*DW-1:0]           mult_res_w,
  output logic [DW+$clog2(LANES)-1:0]   dot_res_w,
  output logic                          mult_res_v_w,
  output logic                          busy
);

  localparam int DOT_W = DW + $clog2(LANES);
  localparam int SUM_W = 2*DW + $clog2(LANES);

  logic [PIPE_LAT-1:0]     vld_q;
  logic                    ce_p0;
  logic                    ce_p1;
  logic                    ce_p2;
  logic [LANES*DW-1:0]     fea_p0_q;
  logic [LANES*DW-1:0]     coef_p0_q;
  logic [LANES-1:0]        mask_p0_q;
  logic signed [2*DW-1:0]  prod_p1 [LANES];
  logic signed [SUM_W-1:0] sum_p1;
  logic [LANES*DW-1:0]     mult_p2_d;
  logic [LANES*DW-1:0]     mult_p2_q;
  logic [DOT_W-1:0]        dot_p2_d;
  logic [DOT_W-1:0]        dot_p2_q;

  assign ce_p0 = data_v   & ~halt;
  assign ce_p1 = vld_q[0] & ~halt;
  assign ce_p2 = vld_q[1] & ~halt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (!halt) begin
      vld_q <= {vld_q[PIPE_LAT-2:0], data_v};
    end
  end

  // S0: operand and mask capture
  always_ff @(posedge clk) begin
    if (ce_p0) begin
      fea_p0_q  <= in_fea_w;
      coef_p0_q <= a_mx_w;
      mask_p0_q <= lane_mask;
    end
  end

  // S1: full-width signed products, one DSP lane each
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_mult_lane #(
      .DW (DW)
    ) u_lane (
      .clk    (clk),
      .ce_i   (ce_p1),
      .en_i   (mask_p0_q[i]),
      .a_i    (fea_p0_q[i*DW +: DW]),
      .b_i    (coef_p0_q[i*DW +: DW]),
      .prod_o (prod_p1[i])
    );
  end

  // The dot product sums unscaled products so only one truncation is applied.
  always_comb begin
    mult_p2_d = '0;
    sum_p1    = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_p1 = sum_p1 + SUM_W'(prod_p1[i]);
`ifdef CONV_VEC_MULT_SAT_EN
      mult_p2_d[i*DW +: DW] = DW'(sat_s(wide_t'(prod_p1[i] >>> FRAC), DW));
`else
      mult_p2_d[i*DW +: DW] = DW'(prod_p1[i] >>> FRAC);
`endif
    end
`ifdef CONV_VEC_MULT_SAT_EN
    dot_p2_d = DOT_W'(sat_s(wide_t'(sum_p1 >>> FRAC), DOT_W));
`else
    dot_p2_d = DOT_W'(sum_p1 >>> FRAC);
`endif
  end

  // S2: scaled, reduced results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_p2_q <= '0;
      dot_p2_q  <= '0;
    end else if (ce_p2) begin
      mult_p2_q <= mult_p2_d;
      dot_p2_q  <= dot_p2_d;
    end
  end

  assign mult_res_w   = mult_p2_q;
  assign dot_res_w    = dot_p2_q;
  assign mult_res_v_w = vld_q[PIPE_LAT-1];
  assign busy         = |vld_q;

endmodule

// File: tb/tb_conv_vec_mult_pipe.sv
// Self-checking bench for conv_vec_mult_pipe: directed scenarios plus a
// scoreboard fed by an arithmetic reference model of each accepted beat.
module tb_conv_vec_mult_pipe;

  localparam int LANES = 25;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int DOTW  = DW + $clog2(LANES);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                data_v = 1'b0;
  logic                halt = 1'b0;
  logic [LANES-1:0]    lane_mask = '1;
  logic [LANES*DW-1:0] in_fea_w = '0;
  logic [LANES*DW-1:0] a_mx_w = '0;
  logic [LANES*DW-1:0] mult_res_w;
  logic [DOTW-1:0]     dot_res_w;
  logic                mult_res_v_w;
  logic                busy;

  conv_vec_mult_pipe #(.LANES(LANES), .DW(DW), .FRAC(FRAC)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_v       (data_v),
    .halt         (halt),
    .lane_mask    (lane_mask),
    .in_fea_w     (in_fea_w),
    .a_mx_w       (a_mx_w),
    .mult_res_w   (mult_res_w),
    .dot_res_w    (dot_res_w),
    .mult_res_v_w (mult_res_v_w),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DW-1:0] mult;
    logic [DOTW-1:0]     dot;
    int                  k;
  } exp_t;

  exp_t                sb[$];
  int                  vecs = 0;
  int                  errs = 0;
  int                  ecnt = 0;
  int                  outs = 0;
  logic                ena_edge = 1'b0;
  logic [LANES*DW-1:0] snap_m = '0;
  logic [DOTW-1:0]     snap_d = '0;
  logic                snap_v = 1'b0;
  logic                snap_b = 1'b0;

  // Reduce an arbitrary integer to a w-bit signed result.
  function automatic longint red(input longint v, input int w);
    longint span;
    longint r;
    span = longint'(1) <<< w;
`ifdef CONV_VEC_MULT_SAT_EN
    r = v;
    if (v >= span / 2) r = span / 2 - 1;
    if (v < -(span / 2)) r = -(span / 2);
`else
    r = v & (span - 1);
    if (r >= span / 2) r = r - span;
`endif
    return r;
  endfunction

  function automatic exp_t model(input logic [LANES*DW-1:0] f,
                                 input logic [LANES*DW-1:0] a,
                                 input logic [LANES-1:0] m);
    exp_t e;
    longint p;
    longint s;
    longint r;
    logic signed [DW-1:0] fx;
    logic signed [DW-1:0] ax;
    s = 0;
    e.mult = '0;
    e.k = 0;
    for (int i = 0; i < LANES; i++) begin
      fx = f[i*DW +: DW];
      ax = a[i*DW +: DW];
      p  = m[i] ? longint'(fx) * longint'(ax) : 0;
      s  = s + p;
      r  = red(p >>> FRAC, DW);
      e.mult[i*DW +: DW] = r[DW-1:0];
    end
    r = red(s >>> FRAC, DOTW);
    e.dot = r[DOTW-1:0];
    return e;
  endfunction

  always @(posedge clk) begin : acc
    exp_t e;
    ena_edge = rst && !halt;
    if (ena_edge) begin
      if (data_v) begin
        e = model(in_fea_w, a_mx_w, lane_mask);
        e.k = ecnt;
        sb.push_back(e);
      end
      ecnt++;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_v;
    if (!rst) begin
      vecs++;
      if (mult_res_v_w !== 1'b0 || busy !== 1'b0 || mult_res_w !== '0 || dot_res_w !== '0) begin
        errs++;
        $display("FAIL reset_hold: v=%b busy=%b dot=%h want all zero", mult_res_v_w, busy, dot_res_w);
      end
    end else if (ena_edge) begin
      exp_v = (sb.size() > 0) && (ecnt - sb[0].k == 3);
      vecs++;
      if (mult_res_v_w !== exp_v) begin
        errs++;
        $display("FAIL valid @%0t: got %b want %b", $time, mult_res_v_w, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        outs++;
        vecs++;
        if (mult_res_w !== e.mult) begin
          errs++;
          $display("FAIL mult @%0t: got %h want %h", $time, mult_res_w, e.mult);
        end
        vecs++;
        if (dot_res_w !== e.dot) begin
          errs++;
          $display("FAIL dot @%0t: got %h want %h", $time, dot_res_w, e.dot);
        end
      end
      vecs++;
      if (busy !== (exp_v || sb.size() > 0)) begin
        errs++;
        $display("FAIL busy @%0t: got %b want %b", $time, busy, (exp_v || sb.size() > 0));
      end
    end else begin
      vecs++;
      if ({mult_res_v_w, busy, dot_res_w, mult_res_w} !== {snap_v, snap_b, snap_d, snap_m}) begin
        errs++;
        $display("FAIL freeze @%0t: got v=%b b=%b dot=%h want v=%b b=%b dot=%h",
                 $time, mult_res_v_w, busy, dot_res_w, snap_v, snap_b, snap_d);
      end
    end
    snap_m = mult_res_w;
    snap_d = dot_res_w;
    snap_v = mult_res_v_w;
    snap_b = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    data_v = 1'b0;
    halt   = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic fill(input logic [DW-1:0] f, input logic [DW-1:0] a);
    for (int i = 0; i < LANES; i++) begin
      in_fea_w[i*DW +: DW] = f;
      a_mx_w[i*DW +: DW]   = a;
    end
  endtask

  task automatic rand_fill();
    for (int i = 0; i < LANES; i++) begin
      in_fea_w[i*DW +: DW] = DW'($urandom);
      a_mx_w[i*DW +: DW]   = DW'($urandom);
      if ($urandom_range(0, 7) == 0) in_fea_w[i*DW +: DW] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) a_mx_w[i*DW +: DW]   = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_v = 1'b0;
    step();
    step();
    vecs++;
    if (mult_res_v_w !== 1'b0 || busy !== 1'b0 || mult_res_w !== '0 || dot_res_w !== '0) begin
      errs++;
      $display("FAIL reset_state: v=%b busy=%b dot=%h want 0 0 0", mult_res_v_w, busy, dot_res_w);
    end
    lane_mask = '1;
    fill(16'h0003, 16'h0100);
    rst = 1'b1;
    data_v = 1'b1;
    step();
    data_v = 1'b0;
    step();
    step();
    vecs++;
    if (mult_res_v_w !== 1'b1 || mult_res_w[DW-1:0] !== 16'h0003 || dot_res_w !== 21'd75) begin
      errs++;
      $display("FAIL first_beat: v=%b lane0=%h dot=%h want 1 0003 0004b",
               mult_res_v_w, mult_res_w[DW-1:0], dot_res_w);
    end
    drain();
  endtask

  task automatic test_basic();
    logic [LANES*DW-1:0] exp_m;
    for (int i = 0; i < LANES; i++) exp_m[i*DW +: DW] = 16'h0200;
    lane_mask = '1;
    fill(16'h0100, 16'h0200);
    data_v = 1'b1;
    step();
    data_v = 1'b0;
    step();
    vecs++;
    if (mult_res_v_w !== 1'b0) begin
      errs++;
      $display("FAIL basic_early: v=%b want 0", mult_res_v_w);
    end
    step();
    vecs++;
    if (mult_res_v_w !== 1'b1 || mult_res_w !== exp_m || dot_res_w !== 21'h3200) begin
      errs++;
      $display("FAIL basic: v=%b dot=%h mult=%h want 1 03200 all-0200", mult_res_v_w, dot_res_w, mult_res_w);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] want;
`ifdef CONV_VEC_MULT_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'hFF00;
`endif
    lane_mask = '1;
    fill(16'h0000, 16'h0000);
    in_fea_w[DW-1:0] = 16'h7FFF;
    a_mx_w[DW-1:0]   = 16'h7FFF;
    data_v = 1'b1;
    step();
    data_v = 1'b0;
    step();
    step();
    vecs++;
    if (mult_res_v_w !== 1'b1 || mult_res_w[DW-1:0] !== want) begin
      errs++;
      $display("FAIL overflow: v=%b lane0=%h want 1 %h", mult_res_v_w, mult_res_w[DW-1:0], want);
    end
    drain();
  endtask

  task automatic test_mask();
    logic [LANES*DW-1:0] exp_m;
    exp_m = '0;
    exp_m[DW-1:0] = 16'h0100;
    lane_mask = 25'h0000001;
    fill(16'h0100, 16'h0100);
    data_v = 1'b1;
    step();
    data_v = 1'b0;
    step();
    step();
    vecs++;
    if (mult_res_v_w !== 1'b1 || mult_res_w !== exp_m || dot_res_w !== 21'h0100) begin
      errs++;
      $display("FAIL mask: v=%b dot=%h mult=%h want 1 00100 %h", mult_res_v_w, dot_res_w, mult_res_w, exp_m);
    end
    lane_mask = '1;
    drain();
  endtask

  task automatic test_min_min();
    logic [DW-1:0]   want_l;
    logic [DOTW-1:0] want_d;
    logic [2:0]      pat;
`ifdef CONV_VEC_MULT_SAT_EN
    want_l = 16'h7FFF;
    want_d = 21'h0FFFFF;
`else
    want_l = 16'h0000;
    want_d = 21'h000000;
`endif
    lane_mask = '1;
    fill(16'h0000, 16'h0000);
    in_fea_w[DW-1:0] = 16'h8000;
    a_mx_w[DW-1:0]   = 16'h8000;
    data_v = 1'b1;
    step();
    data_v = 1'b0;
    step();
    data_v = 1'b1;
    step();
    pat[2] = mult_res_v_w;
    vecs++;
    if (mult_res_w[DW-1:0] !== want_l || dot_res_w !== want_d) begin
      errs++;
      $display("FAIL min_min: lane0=%h dot=%h want %h %h", mult_res_w[DW-1:0], dot_res_w, want_l, want_d);
    end
    data_v = 1'b0;
    step();
    pat[1] = mult_res_v_w;
    step();
    pat[0] = mult_res_v_w;
    vecs++;
    if (pat !== 3'b101) begin
      errs++;
      $display("FAIL bubble_pattern: got %b want 101", pat);
    end
    drain();
  endtask

  task automatic test_halt();
    int o0;
    int c;
    int accepted;
    o0 = outs;
    c = 0;
    accepted = 0;
    lane_mask = '1;
    data_v = 1'b1;
    while (accepted < 10) begin
      halt = (c >= 2 && c <= 4);
      rand_fill();
      step();
      if (!halt) accepted++;
      c++;
    end
    halt = 1'b0;
    drain();
    vecs++;
    if (outs - o0 != 10 || sb.size() != 0) begin
      errs++;
      $display("FAIL halt_stream: delivered %0d pending %0d want 10 0", outs - o0, sb.size());
    end
  endtask

  task automatic test_random_stream();
    int o0;
    o0 = outs;
    for (int i = 0; i < 60; i++) begin
      data_v    = ($urandom_range(0, 3) != 0);
      halt      = ($urandom_range(0, 4) == 0);
      lane_mask = LANES'({$urandom, $urandom});
      rand_fill();
      step();
    end
    lane_mask = '1;
    drain();
    vecs++;
    if (sb.size() != 0 || outs == o0) begin
      errs++;
      $display("FAIL random_stream: pending %0d delivered %0d want 0 >0", sb.size(), outs - o0);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    lane_mask = '1;
    data_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fill(16'h0100, DW'(16'h0100 + i));
      step();
    end
    data_v = 1'b0;
    vecs++;
    if (mult_res_v_w !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL midflight_pre: v=%b busy=%b want 1 1", mult_res_v_w, busy);
    end
    rst = 1'b0;
    #1;
    sb.delete();
    vecs++;
    if (mult_res_v_w !== 1'b0 || busy !== 1'b0 || mult_res_w !== '0 || dot_res_w !== '0) begin
      errs++;
      $display("FAIL midflight_clear: v=%b busy=%b dot=%h want 0 0 0", mult_res_v_w, busy, dot_res_w);
    end
    step();
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mult_res_v_w === 1'b1) seen++;
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL midflight_ghost: %0d valid cycles after release want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_mask();
    test_min_min();
    test_halt();
    test_random_stream();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/conv_vec_mult_pipe.md
CONV_VEC_MULT_PIPE -- requirements
Module: conv_vec_mult_pipe

Interface
REQ-001 SHALL have parameter: LANES, 25, number of parallel multiplier lanes (1..64).
REQ-002 SHALL have parameter: DW, 16, signed fixed-point operand and result width per lane.
REQ-003 SHALL have parameter: FRAC, 8, fractional bits; the product is shifted right by FRAC.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: data_v  in  1  input vector valid.
REQ-007 SHALL have ports: halt  in  1  pipeline freeze.
REQ-008 SHALL have ports: lane_mask  in  LANES  per-lane enable; a masked lane yields 0.
REQ-009 SHALL have ports: in_fea_w  in  LANES*DW  feature vector; lane i is at [i*DW +: DW].
REQ-010 SHALL have ports: a_mx_w  in  LANES*DW  coefficient vector, packed the same way.
REQ-011 SHALL have ports: mult_res_w  out  LANES*DW  per-lane scaled products.
REQ-012 SHALL have ports: dot_res_w  out  DW+$clog2(LANES)  scaled sum of all lane products.
REQ-013 SHALL have ports: mult_res_v_w  out  1  output valid.
REQ-014 SHALL have ports: busy  out  1  high while any pipeline stage holds valid data.

Function
REQ-015 SHALL be a 3-stage pipeline: S0 registers operands and mask; S1 registers full 2*DW signed products; S2 registers the scaled results.
REQ-016 SHALL assert mult_res_v_w exactly 3 enabled (non-halted) cycles after a data_v beat is accepted.
REQ-017 SHALL accept a beat on every cycle with data_v=1 and halt=0; there SHALL be no backpressure other than halt.
REQ-018 SHALL, while halt=1, hold every stage register, valid bit and output unchanged; data_v SHALL be ignored during halt.
REQ-019 SHALL keep a 3-bit valid shift register; busy SHALL be the OR of its bits.
REQ-020 SHALL clock-enable each stage's data registers only when that stage's incoming valid bit is 1 and halt=0; idle stages SHALL hold their value.
REQ-021 SHALL form lane result i as product[i] arithmetically shifted right by FRAC, truncated toward negative infinity, then reduced to DW bits per REQ-031/REQ-032.
REQ-022 SHALL form dot_res_w in S2 as the sum of all LANES full-width products, shifted right by FRAC and reduced to DW+$clog2(LANES) bits by the same rule.
REQ-023 SHALL force the S1 product of a lane masked in S0 to 0.
REQ-024 SHALL handle the boundary case -(2^(DW-1)) * -(2^(DW-1)) with no sign wrap inside the 2*DW product.
REQ-025 SHALL let back-to-back beats stream with one result per cycle; a bubble on data_v SHALL produce a matching bubble on mult_res_v_w.

Reset
REQ-026 SHALL, on rst=0, asynchronously clear the valid shift register, mult_res_v_w, busy, mult_res_w and dot_res_w to 0.
REQ-027 SHALL, on reset asserted mid-operation, discard all in-flight beats; no valid output SHALL appear for them after release.
REQ-028 SHALL accept the first beat on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL define the macro CONV_VEC_MULT_SAT_EN to select result reduction.
REQ-030 SHALL use that macro to control the reduction of each lane result and of dot_res_w to their output widths.
REQ-031 SHALL, with CONV_VEC_MULT_SAT_EN defined, saturate an out-of-range value to the signed maximum or minimum of the output width.
REQ-032 SHALL, without the macro, keep the low bits of the shifted value (two's-complement wrap), matching the legacy [DW+FRAC-1:FRAC] slice.

Structure
REQ-033 SHALL place the default LANES/DW/FRAC values, a PIPE_LAT=3 constant and a signed saturation function in a shared package, conv_pkg.
REQ-034 SHALL instantiate one sub-module per lane, conv_mult_lane: a registered signed DW x DW multiplier with CE, mapping to one DSP.

Verification
REQ-035 SHALL pass this test: LANES=25, DW=16, FRAC=8; all lanes 0x0100 * 0x0200 -> every lane 0x0200 and dot 0x3200, valid exactly 3 cycles later.
REQ-036 SHALL pass this test: 10 consecutive beats with halt=1 on cycles 2-4 -> outputs frozen during the halt, all 10 results delivered in order, none lost or duplicated.
REQ-037 SHALL pass this test: lane 0 = 0x7FFF * 0x7FFF, SAT_EN defined -> lane 0 = 0x7FFF; without SAT_EN -> 0xFF00 (wrap).
REQ-038 SHALL pass this test: lane_mask=0x0000001 with all operands 0x0100 -> lane 0 = 0x0100, others 0, dot 0x0100.
REQ-039 SHALL pass this test: rst pulsed low while 2 beats are in flight -> outputs 0 immediately, no valid pulse for those beats afterward.
REQ-040 SHALL pass this test: -0x8000 * -0x8000 with FRAC=8, SAT_EN defined -> 0x7FFF; data_v pattern 1,0,1 -> mult_res_v_w pattern 1,0,1.
